// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory access stage: access size codes,
// FSM state encoding and the alignment rule.
package sys_defs;

    // Access size codes as carried on EX_MEM_mem_size; 2'b11 is reserved.
    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    // Memory stage controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } mem_state_t;

    // True when the access cannot be issued: unaligned half/word or reserved size.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = addr_lo[0];
            MEM_W:   bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// Combinational byte-lane logic: store steering, byte enables,
// load lane extraction with sign/zero extension, and the misalign check.
module mem_align
    import sys_defs::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the returned word.
    always_comb begin
        byte_sel = load_raw[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
    end

    // Size-dependent lane steering, enables and load extension.
    always_comb begin
        be         = '0;
        lane_wdata = store_data;
        load_data  = '0;
        misalign   = size_misaligned(size, addr_lo);
        case (size)
            MEM_B: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{store_data[7:0]}};
                load_data  = {{24{~uns & byte_sel[7]}}, byte_sel};
            end
            MEM_H: begin
                be         = 4'b0011 << addr_lo;
                lane_wdata = {2{store_data[15:0]}};
                load_data  = {{16{~uns & half_sel[15]}}, half_sel};
            end
            MEM_W: begin
                be         = 4'b1111;
                lane_wdata = store_data;
                load_data  = load_raw;
            end
            default: begin
                be = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: issues data memory requests for loads and
// stores, waits for grant and read data, and stalls upstream while busy.
module mem_access_stage
    import sys_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEM_alu_res,
    input  logic [31:0] EX_MEM_mem_din,
    input  logic        EX_MEM_rd_mem,
    input  logic        EX_MEM_wr_mem,
    input  logic [1:0]  EX_MEM_mem_size,
    input  logic        EX_MEM_mem_uns,
    input  logic        EX_MEM_vld,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] MEM_data,
    output logic        MEM_vld,
    output logic        MEM_busy,
    output logic        MEM_misalign
);

    mem_state_t  state, state_d;
    logic [31:0] addr_q;
    logic [31:0] din_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic        issue;

    logic        in_idle;
    logic        mem_op;
    logic        rd_and_wr;
    logic [31:0] sel_addr;
    logic [31:0] sel_din;
    logic [1:0]  sel_size;
    logic        sel_uns;
    logic        sel_we;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misalign;

    // In IDLE the live inputs drive the request; afterwards the latched copy does,
    // so a single alignment unit serves both the issue cycle and later cycles.
    always_comb begin
        in_idle   = (state == IDLE);
        mem_op    = EX_MEM_vld & (EX_MEM_rd_mem | EX_MEM_wr_mem);
        rd_and_wr = EX_MEM_rd_mem & EX_MEM_wr_mem;
        sel_addr  = in_idle ? EX_MEM_alu_res  : addr_q;
        sel_din   = in_idle ? EX_MEM_mem_din  : din_q;
        sel_size  = in_idle ? EX_MEM_mem_size : size_q;
        sel_uns   = in_idle ? EX_MEM_mem_uns  : uns_q;
        sel_we    = in_idle ? EX_MEM_wr_mem   : we_q;
    end

    mem_align u_align (
        .addr_lo    (sel_addr[1:0]),
        .size       (sel_size),
        .uns        (sel_uns),
        .store_data (sel_din),
        .load_raw   (dmem_rdata),
        .be         (al_be),
        .lane_wdata (al_wdata),
        .load_data  (al_load),
        .misalign   (al_misalign)
    );

    // Next-state and output decode; completions take precedence and a new op is
    // only accepted from IDLE. Reset forces every output low.
    always_comb begin
        state_d      = state;
        issue        = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_be      = '0;
        dmem_wdata   = '0;
        MEM_data     = '0;
        MEM_vld      = 1'b0;
        MEM_busy     = 1'b0;
        MEM_misalign = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (EX_MEM_vld && !(EX_MEM_rd_mem || EX_MEM_wr_mem)) begin
                        MEM_data = EX_MEM_alu_res;
                        MEM_vld  = 1'b1;
                    end else if (mem_op && (rd_and_wr || al_misalign)) begin
                        MEM_misalign = 1'b1;
                    end else if (mem_op) begin
                        issue      = 1'b1;
                        dmem_req   = 1'b1;
                        dmem_we    = sel_we;
                        dmem_addr  = {sel_addr[31:2], 2'b00};
                        dmem_be    = al_be;
                        dmem_wdata = al_wdata;
                        if (EX_MEM_wr_mem && dmem_gnt) begin
                            MEM_data = EX_MEM_alu_res;
                            MEM_vld  = 1'b1;
                        end else if (EX_MEM_rd_mem && dmem_gnt && dmem_rvalid) begin
                            MEM_data = al_load;
                            MEM_vld  = 1'b1;
                        end else begin
                            MEM_busy = 1'b1;
                            state_d  = dmem_gnt ? WAIT_R : REQ;
                        end
                    end
                end
                REQ: begin
                    dmem_req   = 1'b1;
                    dmem_we    = sel_we;
                    dmem_addr  = {sel_addr[31:2], 2'b00};
                    dmem_be    = al_be;
                    dmem_wdata = al_wdata;
                    if (dmem_gnt && we_q) begin
                        MEM_data = EX_MEM_alu_res;
                        MEM_vld  = 1'b1;
                        state_d  = IDLE;
                    end else if (dmem_gnt && dmem_rvalid) begin
                        MEM_data = al_load;
                        MEM_vld  = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        MEM_busy = 1'b1;
                        if (dmem_gnt) begin
                            state_d = WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (dmem_rvalid) begin
                        MEM_data = al_load;
                        MEM_vld  = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        MEM_busy = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register and request attribute latches, captured on issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            din_q  <= '0;
            size_q <= '0;
            uns_q  <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            state <= state_d;
            if (issue) begin
                addr_q <= EX_MEM_alu_res;
                din_q  <= EX_MEM_mem_din;
                size_q <= EX_MEM_mem_size;
                uns_q  <= EX_MEM_mem_uns;
                we_q   <= EX_MEM_wr_mem;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a
// randomized transaction loop against a byte-level reference model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] EX_MEM_alu_res, EX_MEM_mem_din;
    logic        EX_MEM_rd_mem, EX_MEM_wr_mem, EX_MEM_mem_uns, EX_MEM_vld;
    logic [1:0]  EX_MEM_mem_size;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] MEM_data;
    logic        MEM_vld, MEM_busy, MEM_misalign;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .EX_MEM_alu_res(EX_MEM_alu_res), .EX_MEM_mem_din(EX_MEM_mem_din),
        .EX_MEM_rd_mem(EX_MEM_rd_mem), .EX_MEM_wr_mem(EX_MEM_wr_mem),
        .EX_MEM_mem_size(EX_MEM_mem_size), .EX_MEM_mem_uns(EX_MEM_mem_uns),
        .EX_MEM_vld(EX_MEM_vld),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .MEM_data(MEM_data), .MEM_vld(MEM_vld), .MEM_busy(MEM_busy),
        .MEM_misalign(MEM_misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference model (byte-level) ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic m_mis(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] a);
        if (rd && wr) return 1'b1;
        if (sz == 2'd3) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] b = '0;
        for (int i = 0; i < nbytes(sz); i++) b[(a % 4) + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a, input logic uns, input logic [31:0] rd);
        logic [31:0] v = '0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*((a % 4) + i) +: 8];
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        EX_MEM_vld = 0; EX_MEM_rd_mem = 0; EX_MEM_wr_mem = 0;
        EX_MEM_mem_size = 2'd0; EX_MEM_mem_uns = 0;
        EX_MEM_alu_res = '0; EX_MEM_mem_din = '0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d);
        EX_MEM_vld = 1; EX_MEM_rd_mem = rd; EX_MEM_wr_mem = wr;
        EX_MEM_mem_size = sz; EX_MEM_mem_uns = uns;
        EX_MEM_alu_res = a; EX_MEM_mem_din = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1;
        set_op(1, 0, 2'd2, 0, 32'h0000_0100, 32'h0);
        dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        #4;
        n_checks++; if (dmem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", dmem_req); else n_pass++;
        n_checks++; if (MEM_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", MEM_vld); else n_pass++;
        n_checks++; if (MEM_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", MEM_busy); else n_pass++;
        n_checks++; if (MEM_misalign !== 1'b0) $display("FAIL reset_mis: got %b want 0", MEM_misalign); else n_pass++;
        n_checks++; if (MEM_data !== 32'h0) $display("FAIL reset_data: got %h want 0", MEM_data); else n_pass++;
        n_checks++; if (dmem_be !== 4'h0) $display("FAIL reset_be: got %b want 0", dmem_be); else n_pass++;
        tick();
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_nonmem();
        set_op(0, 0, 2'd0, 0, 32'h0000_1234, 32'h0);
        #4;
        n_checks++; if (MEM_data !== 32'h1234) $display("FAIL nonmem_data: got %h want 00001234", MEM_data); else n_pass++;
        n_checks++; if (MEM_vld !== 1'b1) $display("FAIL nonmem_vld: got %b want 1", MEM_vld); else n_pass++;
        n_checks++; if (MEM_busy !== 1'b0) $display("FAIL nonmem_busy: got %b want 0", MEM_busy); else n_pass++;
        n_checks++; if (dmem_req !== 1'b0) $display("FAIL nonmem_req: got %b want 0", dmem_req); else n_pass++;
        tick();
        idle_inputs();
        #4;
        n_checks++; if (MEM_vld !== 1'b0) $display("FAIL invalid_vld: got %b want 0", MEM_vld); else n_pass++;
        tick();
    endtask

    task automatic test_store_byte();
        set_op(0, 1, 2'd0, 0, 32'h0000_1003, 32'h0000_00AB);
        for (int c = 0; c < 3; c++) begin
            dmem_gnt = (c == 2);
            #4;
            n_checks++; if (dmem_req !== 1'b1) $display("FAIL sb_req c%0d: got %b want 1", c, dmem_req); else n_pass++;
            n_checks++; if (dmem_we !== 1'b1) $display("FAIL sb_we c%0d: got %b want 1", c, dmem_we); else n_pass++;
            n_checks++; if (dmem_be !== 4'b1000) $display("FAIL sb_be c%0d: got %b want 1000", c, dmem_be); else n_pass++;
            n_checks++; if (dmem_wdata !== 32'hABAB_ABAB) $display("FAIL sb_wdata c%0d: got %h want ababab ab", c, dmem_wdata); else n_pass++;
            n_checks++; if (dmem_addr !== 32'h0000_1000) $display("FAIL sb_addr c%0d: got %h want 00001000", c, dmem_addr); else n_pass++;
            n_checks++; if (MEM_busy !== (c < 2)) $display("FAIL sb_busy c%0d: got %b want %b", c, MEM_busy, (c < 2)); else n_pass++;
            n_checks++; if (MEM_vld !== (c == 2)) $display("FAIL sb_vld c%0d: got %b want %b", c, MEM_vld, (c == 2)); else n_pass++;
            if (c == 2) begin
                n_checks++; if (MEM_data !== 32'h1003) $display("FAIL sb_data: got %h want 00001003", MEM_data); else n_pass++;
            end
            tick();
        end
        idle_inputs();
        #4;
        n_checks++; if (dmem_req !== 1'b0) $display("FAIL sb_after_req: got %b want 0", dmem_req); else n_pass++;
        tick();
    endtask

    task automatic test_load_half();
        for (int u = 0; u < 2; u++) begin
            logic [31:0] want;
            want = (u == 1) ? 32'h0000_8001 : 32'hFFFF_8001;
            set_op(1, 0, 2'd1, u[0], 32'h0000_2002, 32'h0);
            for (int c = 0; c < 5; c++) begin
                dmem_gnt    = (c == 1);
                dmem_rvalid = (c == 0) || (c == 4);
                dmem_rdata  = (c == 4) ? 32'h8001_0000 : 32'h1234_5678;
                if (c == 2) begin
                    EX_MEM_alu_res = 32'h0000_2001; EX_MEM_mem_size = 2'd2; EX_MEM_mem_uns = ~u[0];
                end
                #4;
                n_checks++; if (dmem_req !== (c <= 1)) $display("FAIL lh_req u%0d c%0d: got %b want %b", u, c, dmem_req, (c <= 1)); else n_pass++;
                n_checks++; if (MEM_vld !== (c == 4)) $display("FAIL lh_vld u%0d c%0d: got %b want %b", u, c, MEM_vld, (c == 4)); else n_pass++;
                n_checks++; if (MEM_busy !== (c < 4)) $display("FAIL lh_busy u%0d c%0d: got %b want %b", u, c, MEM_busy, (c < 4)); else n_pass++;
                if (c == 0) begin
                    n_checks++; if (dmem_be !== 4'b1100) $display("FAIL lh_be u%0d: got %b want 1100", u, dmem_be); else n_pass++;
                end
                if (c == 4) begin
                    n_checks++; if (MEM_data !== want) $display("FAIL lh_data u%0d: got %h want %h", u, MEM_data, want); else n_pass++;
                end
                tick();
            end
            idle_inputs();
        end
    endtask

    task automatic test_misalign();
        logic [35:0] cases [5];
        cases[0] = {1'b1, 1'b0, 2'd2, 32'h0000_3001};
        cases[1] = {1'b0, 1'b1, 2'd1, 32'h0000_3001};
        cases[2] = {1'b1, 1'b0, 2'd3, 32'h0000_3000};
        cases[3] = {1'b1, 1'b1, 2'd2, 32'h0000_3000};
        cases[4] = {1'b0, 1'b1, 2'd2, 32'h0000_3002};
        for (int i = 0; i < 5; i++) begin
            set_op(cases[i][35], cases[i][34], cases[i][33:32], 0, cases[i][31:0], 32'h5555_5555);
            dmem_gnt = 1; dmem_rvalid = 1;
            #4;
            n_checks++; if (MEM_misalign !== 1'b1) $display("FAIL mis_flag%0d: got %b want 1", i, MEM_misalign); else n_pass++;
            n_checks++; if (dmem_req !== 1'b0) $display("FAIL mis_req%0d: got %b want 0", i, dmem_req); else n_pass++;
            n_checks++; if (MEM_vld !== 1'b0) $display("FAIL mis_vld%0d: got %b want 0", i, MEM_vld); else n_pass++;
            n_checks++; if (MEM_busy !== 1'b0) $display("FAIL mis_busy%0d: got %b want 0", i, MEM_busy); else n_pass++;
            tick();
            idle_inputs();
            #4;
            n_checks++; if (MEM_misalign !== 1'b0) $display("FAIL mis_clear%0d: got %b want 0", i, MEM_misalign); else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        set_op(1, 0, 2'd2, 0, 32'h0000_4000, 32'h0);
        dmem_gnt = 1;
        #4;
        n_checks++; if (MEM_busy !== 1'b1) $display("FAIL rstmid_busy: got %b want 1", MEM_busy); else n_pass++;
        tick();
        dmem_gnt = 0;
        rst = 1;
        #4;
        n_checks++; if (MEM_busy !== 1'b0) $display("FAIL rstmid_busy_rst: got %b want 0", MEM_busy); else n_pass++;
        n_checks++; if (dmem_req !== 1'b0) $display("FAIL rstmid_req_rst: got %b want 0", dmem_req); else n_pass++;
        tick();
        rst = 0;
        idle_inputs();
        dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
        #4;
        n_checks++; if (MEM_vld !== 1'b0) $display("FAIL rstmid_stale_vld: got %b want 0", MEM_vld); else n_pass++;
        n_checks++; if (MEM_busy !== 1'b0) $display("FAIL rstmid_stale_busy: got %b want 0", MEM_busy); else n_pass++;
        tick();
        idle_inputs();
        set_op(0, 0, 2'd0, 0, 32'h0000_0077, 32'h0);
        #4;
        n_checks++; if (MEM_vld !== 1'b1 || MEM_data !== 32'h77) $display("FAIL rstmid_idle: got vld %b data %h want 1 00000077", MEM_vld, MEM_data); else n_pass++;
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4] = '{32'h0000_5000, 32'h0000_5001, 32'h0000_5002, 32'h0000_5003};
        logic [1:0]  szs   [4] = '{2'd2, 2'd0, 2'd1, 2'd0};
        logic        wrs   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        unss  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] rds   [4] = '{32'hDEAD_BEEF, 32'h0000_8000, 32'h0, 32'hAB00_0000};
        logic [31:0] wants [4] = '{32'hDEAD_BEEF, 32'hFFFF_FF80, 32'h0000_5002, 32'h0000_00AB};
        for (int i = 0; i < 4; i++) begin
            set_op(~wrs[i], wrs[i], szs[i], unss[i], addrs[i], 32'h0000_1122);
            dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = rds[i];
            #4;
            n_checks++; if (dmem_req !== 1'b1) $display("FAIL b2b_req%0d: got %b want 1", i, dmem_req); else n_pass++;
            n_checks++; if (MEM_vld !== 1'b1) $display("FAIL b2b_vld%0d: got %b want 1", i, MEM_vld); else n_pass++;
            n_checks++; if (MEM_busy !== 1'b0) $display("FAIL b2b_busy%0d: got %b want 0", i, MEM_busy); else n_pass++;
            n_checks++; if (MEM_data !== wants[i]) $display("FAIL b2b_data%0d: got %h want %h", i, MEM_data, wants[i]); else n_pass++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int k = 0; k < 120; k++) begin
            int          kind, gd, rdly, done;
            logic        rd, wr, uns, mis;
            logic [1:0]  sz;
            logic [31:0] a, d, rdat, want;
            kind = $urandom_range(0, 9);
            rd   = (kind >= 2 && kind <= 5);
            wr   = (kind >= 6);
            if ($urandom_range(0, 15) == 0) begin rd = 1; wr = 1; end
            sz   = 2'($urandom_range(0, 3));
            a    = $urandom;
            if ($urandom_range(0, 2) != 0 && sz != 2'd3) a = a - (a % nbytes(sz));
            d    = $urandom;
            uns  = 1'($urandom_range(0, 1));
            rdat = $urandom;
            gd   = $urandom_range(0, 3);
            rdly = $urandom_range(0, 3);
            set_op(rd, wr, sz, uns, a, d);
            mis = m_mis(rd, wr, sz, a);
            if (!rd && !wr) begin
                #4;
                n_checks++; if (MEM_vld !== 1'b1 || MEM_data !== a || MEM_busy !== 1'b0 || dmem_req !== 1'b0)
                    $display("FAIL rnd_pass op%0d: got vld %b data %h busy %b req %b want 1 %h 0 0", k, MEM_vld, MEM_data, MEM_busy, dmem_req, a);
                else n_pass++;
                tick();
            end else if (mis) begin
                dmem_gnt = 1'($urandom_range(0, 1));
                #4;
                n_checks++; if (MEM_misalign !== 1'b1 || dmem_req !== 1'b0 || MEM_vld !== 1'b0 || MEM_busy !== 1'b0)
                    $display("FAIL rnd_mis op%0d: got mis %b req %b vld %b busy %b want 1 0 0 0", k, MEM_misalign, dmem_req, MEM_vld, MEM_busy);
                else n_pass++;
                tick();
            end else begin
                done = wr ? gd : gd + rdly;
                want = wr ? a : m_load(sz, a, uns, rdat);
                for (int c = 0; c <= done; c++) begin
                    dmem_gnt    = (c == gd);
                    dmem_rvalid = (c < gd) ? 1'($urandom_range(0, 1)) : (rd && c == done);
                    dmem_rdata  = (c == done) ? rdat : $urandom;
                    #4;
                    n_checks++; if (dmem_req !== (c <= gd)) $display("FAIL rnd_req op%0d c%0d: got %b want %b", k, c, dmem_req, (c <= gd)); else n_pass++;
                    if (c <= gd) begin
                        n_checks++; if (dmem_addr !== {a[31:2], 2'b00} || dmem_be !== m_be(sz, a) || dmem_we !== wr)
                            $display("FAIL rnd_attr op%0d c%0d: got addr %h be %b we %b want %h %b %b", k, c, dmem_addr, dmem_be, dmem_we, {a[31:2], 2'b00}, m_be(sz, a), wr);
                        else n_pass++;
                        if (wr) begin
                            n_checks++; if (dmem_wdata !== m_wdata(sz, d)) $display("FAIL rnd_wdata op%0d c%0d: got %h want %h", k, c, dmem_wdata, m_wdata(sz, d)); else n_pass++;
                        end
                    end
                    n_checks++; if (MEM_vld !== (c == done) || MEM_busy !== (c != done))
                        $display("FAIL rnd_hs op%0d c%0d: got vld %b busy %b want %b %b", k, c, MEM_vld, MEM_busy, (c == done), (c != done));
                    else n_pass++;
                    if (c == done) begin
                        n_checks++; if (MEM_data !== want) $display("FAIL rnd_data op%0d: got %h want %h", k, MEM_data, want); else n_pass++;
                    end
                    tick();
                end
            end
            idle_inputs();
            if ($urandom_range(0, 2) == 0) begin
                #4;
                n_checks++; if (MEM_vld !== 1'b0 || MEM_busy !== 1'b0 || dmem_req !== 1'b0)
                    $display("FAIL rnd_gap op%0d: got vld %b busy %b req %b want 0 0 0", k, MEM_vld, MEM_busy, dmem_req);
                else n_pass++;
                tick();
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        #1;
        test_reset();
        test_nonmem();
        test_store_byte();
        test_load_half();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port `EX_MEM_alu_res`, input, 32 bits: ALU result; this is the byte address for memory ops.
REQ-004 SHALL have port `EX_MEM_mem_din`, input, 32 bits: store data (forwarded rs2).
REQ-005 SHALL have port `EX_MEM_rd_mem`, input, 1 bit: the instruction is a load.
REQ-006 SHALL have port `EX_MEM_wr_mem`, input, 1 bit: the instruction is a store.
REQ-007 SHALL have port `EX_MEM_mem_size`, input, 2 bits: access size, 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port `EX_MEM_mem_uns`, input, 1 bit: zero-extend the load result.
REQ-009 SHALL have port `EX_MEM_vld`, input, 1 bit: the instruction is valid.
REQ-010 SHALL have ports `dmem_req`, `dmem_we` (output, 1 bit each), `dmem_addr` (output, 32 bits), `dmem_be` (output, 4 bits) and `dmem_wdata` (output, 32 bits): data memory request.
REQ-011 SHALL have ports `dmem_gnt` (input, 1 bit), `dmem_rvalid` (input, 1 bit) and `dmem_rdata` (input, 32 bits): data memory response.
REQ-012 SHALL have port `MEM_data`, output, 32 bits: stage result, also the forwarding source for the execute stage.
REQ-013 SHALL have port `MEM_vld`, output, 1 bit: `MEM_data` is a completed, valid result this cycle.
REQ-014 SHALL have port `MEM_busy`, output, 1 bit: stall request to all upstream stages.
REQ-015 SHALL have port `MEM_misalign`, output, 1 bit: misaligned or reserved-size access trap.

Function
REQ-016 SHALL implement the FSM states IDLE, REQ and WAIT_R.
REQ-017 SHALL pass a valid non-memory instruction through combinationally in IDLE: `MEM_data`=`EX_MEM_alu_res`, `MEM_vld`=1, `MEM_busy`=0.
REQ-018 SHALL treat an access as misaligned when any of the following holds: half with addr[0]=1; word with addr[1:0]≠0; size 11.
- On a valid rd/wr misaligned access: `MEM_misalign`=1 and `MEM_vld`=0 for one cycle, no `dmem_req`, FSM stays IDLE.
REQ-019 SHALL, on a valid aligned memory op in IDLE, drive `dmem_req`=1 in the same cycle and go to REQ.
- `dmem_addr` = {addr[31:2],2'b00}.
- `dmem_we` = `EX_MEM_wr_mem`.
- `dmem_be`: byte → 0001<<addr[1:0]; half → 0011<<addr[1:0]; word → 1111.
- `dmem_wdata`: byte replicated ×4; half replicated ×2; word unchanged.
REQ-020 SHALL hold `dmem_req`, `dmem_addr`, `dmem_we`, `dmem_be` and `dmem_wdata` stable until the cycle `dmem_gnt`=1.
REQ-021 SHALL complete a store in the cycle `dmem_gnt`=1: `MEM_vld`=1, `MEM_data`=`EX_MEM_alu_res`, FSM to IDLE.
REQ-022 SHALL move a load to WAIT_R on `dmem_gnt`=1 and complete it in the cycle `dmem_rvalid`=1.
- `MEM_data` = byte/half lane selected by the registered addr[1:0], sign- or zero-extended per the registered `mem_uns`.
- `MEM_vld`=1, FSM to IDLE.
- `dmem_gnt` and `dmem_rvalid` in the same cycle SHALL complete the load from REQ directly.
REQ-023 SHALL drive `MEM_busy`=1 whenever a valid aligned memory op is in progress and is not completing this cycle.
- This includes the IDLE cycle in which the request is issued, unless `dmem_gnt` (store) or `dmem_gnt`&`dmem_rvalid` (load) arrives in that same cycle.
REQ-024 SHALL rely on upstream holding the EX_MEM inputs stable while `MEM_busy`=1.
- Address, size and uns SHALL still be latched on issue, so a load result is independent of the inputs in WAIT_R.
REQ-025 SHALL ignore `dmem_rvalid` in IDLE and in REQ when no grant has been given.
REQ-026 SHALL drive `MEM_vld`=0 and no request when `EX_MEM_vld`=0, and also when both rd and wr are set.
- The rd-and-wr case SHALL be flagged as misaligned.
REQ-027 SHALL give load-complete precedence over a new request in the same cycle.
- A new op SHALL be accepted only in IDLE; back-to-back throughput is one access per two cycles minimum, and one per cycle with zero-wait memory.

Reset
REQ-028 SHALL, on `rst`=1 at a clock edge, set the FSM to IDLE and clear all latched address, size and uns registers.
REQ-029 SHALL drive the following while in reset: `dmem_req`=0, `MEM_vld`=0, `MEM_busy`=0, `MEM_misalign`=0, `MEM_data`=0, `dmem_be`=0.
REQ-030 SHALL abort any access in progress when reset is asserted mid-access; a later stale `dmem_rvalid` is ignored per REQ-025.

Structure
REQ-031 SHALL define the size codes (`MEM_B`, `MEM_H`, `MEM_W`) and the FSM state enum in the shared `sys_defs` package.
REQ-032 SHALL instantiate one combinational sub-module, `mem_align`, which performs byte-lane steering, byte-enable generation, load extraction and extension, and the misalign check.

Verification
REQ-033 SHALL cover: non-mem op, `EX_MEM_alu_res`=0x1234 → same cycle `MEM_data`=0x1234, `MEM_vld`=1, `MEM_busy`=0.
REQ-034 SHALL cover: sb at 0x1003 of 0xAB, gnt delayed 2 cycles → `dmem_be`=1000, `dmem_wdata`=0xABABABAB, `dmem_addr`=0x1000, held 3 cycles, `MEM_busy`=1 for 2 cycles.
REQ-035 SHALL cover: lh signed at 0x2002, rdata=0x8001_0000, rvalid 3 cycles after gnt → `MEM_data`=0xFFFF8001; lhu → 0x00008001.
REQ-036 SHALL cover: lw at 0x3001 → `MEM_misalign`=1, `dmem_req` never asserted, `MEM_vld`=0.
REQ-037 SHALL cover: lw issued, `rst` asserted in WAIT_R, then rvalid after reset → FSM IDLE, `MEM_vld` stays 0.
REQ-038 SHALL cover: lw with gnt and rvalid in the issue cycle, rdata=0xDEADBEEF → `MEM_vld`=1, `MEM_busy`=0, `MEM_data`=0xDEADBEEF.
